// File: rtl/mem_write_monitor.sv
// rtl/mem_write_monitor.sv - watches processor stores and reports pass/fail/timeout
// Fully registered monitor; the first RUN-state store decides the outcome.
module mem_write_monitor #(
    parameter int WIDTH    = 32,
    parameter int EXP_ADR  = 20,
    parameter int EXP_DATA = 7,
    parameter int TIMEOUT  = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memread,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic             misalign,
    output logic [15:0]      write_count,
    output logic [15:0]      read_count,
    output logic [15:0]      cycle_count,
    output logic [WIDTH-1:0] last_adr,
    output logic [WIDTH-1:0] last_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TOUT
    } state_t;

    localparam logic [WIDTH-1:0] EXP_ADR_W  = WIDTH'(EXP_ADR);
    localparam logic [WIDTH-1:0] EXP_DATA_W = WIDTH'(EXP_DATA);
    localparam logic [15:0]      TOUT_LAST  = 16'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [15:0]      write_count_q, write_count_d;
    logic [15:0]      read_count_q, read_count_d;
    logic [15:0]      cycle_count_q, cycle_count_d;
    logic [WIDTH-1:0] last_adr_q, last_adr_d;
    logic [WIDTH-1:0] last_data_q, last_data_d;
    logic             misalign_q, misalign_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             timeout_q, timeout_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        state_d       = state_q;
        write_count_d = write_count_q;
        read_count_d  = read_count_q;
        cycle_count_d = cycle_count_q;
        last_adr_d    = last_adr_q;
        last_data_d   = last_data_q;
        misalign_d    = misalign_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                cycle_count_d = sat_inc(cycle_count_q);
                if (memread) begin
                    read_count_d = sat_inc(read_count_q);
                end
                // A store on the timeout cycle still counts as the deciding store.
                if (memwrite) begin
                    last_adr_d    = adr;
                    last_data_d   = writedata;
                    write_count_d = sat_inc(write_count_q);
                    if (adr[1:0] != 2'b00) begin
                        state_d    = S_FAIL;
                        misalign_d = 1'b1;
                    end else if (adr == EXP_ADR_W && writedata == EXP_DATA_W) begin
                        state_d = S_PASS;
                    end else begin
                        state_d = S_FAIL;
                    end
                end else if (cycle_count_q == TOUT_LAST) begin
                    state_d = S_TOUT;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        pass_d    = (state_d == S_PASS);
        fail_d    = (state_d == S_FAIL);
        timeout_d = (state_d == S_TOUT);
        done_d    = pass_d | fail_d | timeout_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            write_count_q <= '0;
            read_count_q  <= '0;
            cycle_count_q <= '0;
            last_adr_q    <= '0;
            last_data_q   <= '0;
            misalign_q    <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            write_count_q <= write_count_d;
            read_count_q  <= read_count_d;
            cycle_count_q <= cycle_count_d;
            last_adr_q    <= last_adr_d;
            last_data_q   <= last_data_d;
            misalign_q    <= misalign_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            timeout_q     <= timeout_d;
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign misalign    = misalign_q;
    assign write_count = write_count_q;
    assign read_count  = read_count_q;
    assign cycle_count = cycle_count_q;
    assign last_adr    = last_adr_q;
    assign last_data   = last_data_q;

endmodule

// File: tb/tb_mem_write_monitor.sv
// tb/tb_mem_write_monitor.sv - scoreboard bench for mem_write_monitor
module tb_mem_write_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        memread;
    logic        memwrite;
    logic [31:0] adr;
    logic [31:0] writedata;
    logic        done, pass, fail, timeout, misalign;
    logic [15:0] write_count, read_count, cycle_count;
    logic [31:0] last_adr, last_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        p, f, t, m;
        logic [15:0] wc, rc, cc;
        logic [31:0] a, d;
    } exp_t;

    typedef struct {
        int          idle;
        logic        rd;
        logic [31:0] a, d;
        logic        p, m;
    } scen_t;

    exp_t sb[$];
    exp_t last_e;

    scen_t tbl[7] = '{
        '{50,  1'b0, 32'd20,         32'd7,          1'b1, 1'b0},
        '{5,   1'b1, 32'd20,         32'd6,          1'b0, 1'b0},
        '{999, 1'b0, 32'd20,         32'd7,          1'b1, 1'b0},
        '{3,   1'b1, 32'd22,         32'd7,          1'b0, 1'b1},
        '{7,   1'b0, 32'd24,         32'd7,          1'b0, 1'b0},
        '{2,   1'b1, 32'd20,         32'h8000_0007,  1'b0, 1'b0},
        '{4,   1'b0, 32'h8000_0014,  32'd7,          1'b0, 1'b0}
    };

    mem_write_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .memread    (memread),
        .memwrite   (memwrite),
        .adr        (adr),
        .writedata  (writedata),
        .done       (done),
        .pass       (pass),
        .fail       (fail),
        .timeout    (timeout),
        .misalign   (misalign),
        .write_count(write_count),
        .read_count (read_count),
        .cycle_count(cycle_count),
        .last_adr   (last_adr),
        .last_data  (last_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".flags"}, 32'({done, pass, fail, timeout, misalign}), 32'd0);
        check({tag, ".wc"}, 32'(write_count), 32'd0);
        check({tag, ".rc"}, 32'(read_count), 32'd0);
        check({tag, ".cc"}, 32'(cycle_count), 32'd0);
        check({tag, ".adr"}, last_adr, 32'd0);
        check({tag, ".data"}, last_data, 32'd0);
    endtask

    // Leaves the DUT in RUN with cycle_count still 0.
    task automatic do_reset(input string tag);
        reset     = 1'b1;
        memread   = 1'b0;
        memwrite  = 1'b0;
        adr       = '0;
        writedata = '0;
        tick();
        tick();
        check_zero({tag, ".rst"});
        reset = 1'b0;
        tick();
    endtask

    task automatic check_outs(input string tag, input exp_t e);
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".pass"}, 32'(pass), 32'(e.p));
        check({tag, ".fail"}, 32'(fail), 32'(e.f));
        check({tag, ".tout"}, 32'(timeout), 32'(e.t));
        check({tag, ".mis"}, 32'(misalign), 32'(e.m));
        check({tag, ".wc"}, 32'(write_count), 32'(e.wc));
        check({tag, ".rc"}, 32'(read_count), 32'(e.rc));
        check({tag, ".cc"}, 32'(cycle_count), 32'(e.cc));
        check({tag, ".adr"}, last_adr, e.a);
        check({tag, ".data"}, last_data, e.d);
    endtask

    task automatic compare_result(input string tag);
        check({tag, ".sb"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            last_e = sb.pop_front();
            check_outs(tag, last_e);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        adr       = a;
        writedata = d;
        tick();
        memwrite  = 1'b0;
        adr       = '0;
        writedata = '0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic early;
        string tag;

        for (int i = 0; i < 7; i++) begin
            tag = $sformatf("s%0d", i);
            do_reset(tag);
            memread = tbl[i].rd;
            repeat (tbl[i].idle) tick();
            memread = 1'b0;
            e.p  = tbl[i].p;
            e.f  = !tbl[i].p;
            e.t  = 1'b0;
            e.m  = tbl[i].m;
            e.wc = 16'd1;
            e.rc = tbl[i].rd ? 16'(tbl[i].idle) : 16'd0;
            e.cc = 16'(tbl[i].idle + 1);
            e.a  = tbl[i].a;
            e.d  = tbl[i].d;
            sb.push_back(e);
            store(tbl[i].a, tbl[i].d);
            compare_result(tag);
            if (i == 1) begin
                memread = 1'b1;
                for (int k = 0; k < 3; k++) store(32'd20, 32'd7);
                memread = 1'b0;
                repeat (4) tick();
                check_outs("s1.frozen", last_e);
            end
        end

        // Timeout with no stores: nothing may assert before the last RUN cycle.
        do_reset("tout");
        e = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 16'd1000, 32'd0, 32'd0};
        sb.push_back(e);
        early = 1'b0;
        repeat (999) begin
            tick();
            if (done || timeout) early = 1'b1;
        end
        check("tout.early", 32'(early), 32'd0);
        tick();
        compare_result("tout");
        store(32'd20, 32'd7);
        check_outs("tout.sticky", last_e);

        // Reset in the middle of RUN discards the reads seen so far.
        do_reset("mid");
        memread = 1'b1;
        repeat (10) tick();
        memread = 1'b0;
        check("mid.rc_pre", 32'(read_count), 32'd10);
        reset = 1'b1;
        tick();
        check_zero("mid.rst");
        reset = 1'b0;
        tick();
        e = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0, 16'd1, 32'd20, 32'd7};
        sb.push_back(e);
        store(32'd20, 32'd7);
        compare_result("mid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
